// File: rtl/sha_absorb.sv
// sha_absorb: AXI-Stream message absorber for the SHA-3 core.
// Packs stream beats into rate-sized blocks (rate chosen per message from S_TUSER)
// and hands each block to the permutation stage over a valid/ready handshake.
// Optional feature macro: SHA_ABSORB_PAD_EN enables FIPS-202 hardware padding
// (0x06 ... 0x80). Without it the message must arrive pre-padded; S_TKEEP is ignored
// and an early TLAST only zero-fills the rest of the block.
module sha_absorb #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [DATA_WIDTH-1:0]   S_TDATA,
    input  logic [DATA_WIDTH/8-1:0] S_TKEEP,
    input  logic                    S_TVALID,
    output logic                    S_TREADY,
    input  logic                    S_TLAST,
    input  logic [1:0]              S_TUSER,
    output logic [1599:0]           Block,
    output logic                    Block_valid,
    input  logic                    Block_ready,
    output logic                    Block_first,
    output logic                    Block_last,
    output logic [1:0]              Mode
);

    localparam int Bytes    = int'(DATA_WIDTH / 8);
    localparam int MaxWords = 144 / Bytes;
`ifdef SHA_ABSORB_PAD_EN
    localparam bit PadEn = 1'b1;
`else
    localparam bit PadEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StFill, StPad, StHold} state_e;

    state_e          st_q, st_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [1599:0]   buf_q, buf_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic            pp_q, pp_d;      // 0x06 still owed to the next word
    logic [1:0]      mode_q, mode_d;

    logic                  accept;
    logic [1:0]            mode_eff;
    logic [7:0]            widx;
    logic [7:0]            last_idx;
    logic                  at_end;
    logic                  keep_full;
    int                    kc;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] beat_word;

    // Number of DATA_WIDTH words in one rate block for a given mode.
    function automatic logic [7:0] rate_words(input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0:    r = 8'(144 / Bytes);
            2'd1:    r = 8'(136 / Bytes);
            2'd2:    r = 8'(104 / Bytes);
            default: r = 8'(72 / Bytes);
        endcase
        return r;
    endfunction

    assign S_TREADY    = ((st_q == StIdle) || (st_q == StFill)) && !ARESET;
    assign accept      = S_TVALID && S_TREADY;
    assign Block       = buf_q;
    assign Block_valid = (st_q == StHold);
    assign Block_first = first_q;
    assign Block_last  = last_q;
    assign Mode        = mode_q;

    // Mode is taken straight from S_TUSER on the first beat, latched afterwards.
    assign mode_eff  = (st_q == StIdle) ? S_TUSER : mode_q;
    assign widx      = (st_q == StIdle) ? 8'd0 : cnt_q;
    assign last_idx  = rate_words(mode_eff) - 8'd1;
    assign at_end    = (widx == last_idx);
    assign keep_full = (S_TKEEP == '1);

    // Incoming beat with the 0x06 pad byte merged in on a short TLAST beat.
    always_comb begin
        kc = 0;
        for (int b = 0; b < Bytes; b++) begin
            if (S_TKEEP[b]) kc = kc + 1;
        end
        beat_word = S_TDATA;
        if (PadEn && S_TLAST) begin
            for (int b = 0; b < Bytes; b++) begin
                if (b == kc) begin
                    beat_word[8*b +: 8] = 8'h06;
                end else if (b > kc) begin
                    beat_word[8*b +: 8] = 8'h00;
                end
            end
        end
    end

    // Next-state, word write and flag updates.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        first_d = first_q;
        last_d  = last_q;
        pp_d    = pp_q;
        mode_d  = mode_q;
        wr_en   = 1'b0;
        wr_word = '0;

        unique case (st_q)
            StIdle, StFill: begin
                if (accept) begin
                    if (st_q == StIdle) begin
                        mode_d  = S_TUSER;
                        first_d = 1'b1;
                    end
                    wr_en   = 1'b1;
                    wr_word = beat_word;
                    if (!S_TLAST) begin
                        last_d = 1'b0;
                        if (at_end) begin
                            st_d = StHold;
                        end else begin
                            st_d  = StFill;
                            cnt_d = widx + 8'd1;
                        end
                    end else if (PadEn && keep_full) begin
                        // Full final beat: the pad byte starts the next word.
                        pp_d = 1'b1;
                        if (at_end) begin
                            last_d = 1'b0;
                            st_d   = StHold;
                        end else begin
                            last_d = 1'b1;
                            st_d   = StPad;
                            cnt_d  = widx + 8'd1;
                        end
                    end else begin
                        last_d = 1'b1;
                        if (at_end) begin
                            if (PadEn) begin
                                wr_word[DATA_WIDTH-1 -: 8] = wr_word[DATA_WIDTH-1 -: 8] | 8'h80;
                            end
                            st_d = StHold;
                        end else begin
                            st_d  = StPad;
                            cnt_d = widx + 8'd1;
                        end
                    end
                end
            end
            StPad: begin
                wr_en = 1'b1;
                if (PadEn && pp_q) begin
                    wr_word[7:0] = 8'h06;
                end
                pp_d = 1'b0;
                if (at_end) begin
                    if (PadEn) begin
                        wr_word[DATA_WIDTH-1 -: 8] = wr_word[DATA_WIDTH-1 -: 8] | 8'h80;
                    end
                    st_d = StHold;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (Block_ready) begin
                    buf_d   = '0;
                    cnt_d   = 8'd0;
                    first_d = 1'b0;
                    if (last_q) begin
                        last_d = 1'b0;
                        st_d   = StIdle;
                    end else if (pp_q) begin
                        // Extra block carrying only padding.
                        last_d = 1'b1;
                        st_d   = StPad;
                    end else begin
                        st_d = StFill;
                    end
                end
            end
            default: st_d = StIdle;
        endcase

        if (wr_en) begin
            for (int w = 0; w < MaxWords; w++) begin
                if (widx == 8'(w)) begin
                    buf_d[w*DATA_WIDTH +: DATA_WIDTH] = wr_word;
                end
            end
        end
    end

    // State register with synchronous reset; reset drops any partial block.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            st_q    <= StIdle;
            cnt_q   <= 8'd0;
            buf_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            pp_q    <= 1'b0;
            mode_q  <= 2'd0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            first_q <= first_d;
            last_q  <= last_d;
            pp_q    <= pp_d;
            mode_q  <= mode_d;
        end
    end

endmodule

// File: tb/tb_sha_absorb.sv
// Directed bench for sha_absorb (DATA_WIDTH=16). Expected blocks come from a
// byte-level padding model; spot values are hand-computed for both builds
// (SHA_ABSORB_PAD_EN defined or not).
module tb_sha_absorb;

    localparam int DW = 16;
`ifdef SHA_ABSORB_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [DW-1:0]   S_TDATA;
    logic [DW/8-1:0] S_TKEEP;
    logic            S_TVALID;
    logic            S_TREADY;
    logic            S_TLAST;
    logic [1:0]      S_TUSER;
    logic [1599:0]   Block;
    logic            Block_valid;
    logic            Block_ready;
    logic            Block_first;
    logic            Block_last;
    logic [1:0]      Mode;

    int            n_vec = 0;
    int            n_err = 0;
    int            nblk_seen;
    logic [1599:0] cap [0:3];
    logic [7:0]    msg [0:255];

    always #5 ACLK = ~ACLK;

    sha_absorb #(.DATA_WIDTH(DW)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .S_TDATA     (S_TDATA),
        .S_TKEEP     (S_TKEEP),
        .S_TVALID    (S_TVALID),
        .S_TREADY    (S_TREADY),
        .S_TLAST     (S_TLAST),
        .S_TUSER     (S_TUSER),
        .Block       (Block),
        .Block_valid (Block_valid),
        .Block_ready (Block_ready),
        .Block_first (Block_first),
        .Block_last  (Block_last),
        .Mode        (Mode)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        int j;
        j = 0;
        for (int i = 199; i >= 0; i--) begin
            if (obs[8*i +: 8] !== exp[8*i +: 8]) j = i;
        end
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: byte %0d got %0h expected %0h", tag, j, obs[8*j +: 8], exp[8*j +: 8]);
        end
    endtask

    function automatic int rate_of(input logic [1:0] m);
        case (m)
            2'd0:    return 144;
            2'd1:    return 136;
            2'd2:    return 104;
            default: return 72;
        endcase
    endfunction

    task automatic pattern(input int len, input int seed);
        for (int i = 0; i < len; i++) msg[i] = 8'(i + seed);
    endtask

    // Send msg[0..len-1] with the given mode, hold Block_ready low for bp valid
    // cycles per block, and compare every delivered block against the model.
    task automatic run_msg(input logic [1:0] mode, input int len, input int bp,
                           input int exp_pad);
        logic [7:0]    exp [0:431];
        logic [1599:0] snap;
        logic [1599:0] ev;
        int rate, nbeats, slen, nblk, b, bi, vcnt, pads;
        rate   = rate_of(mode);
        nbeats = (len == 0) ? 1 : (len + 1) / 2;
        for (int i = 0; i < 432; i++) exp[i] = 8'h00;
        for (int i = 0; i < len; i++) exp[i] = msg[i];
        if (PAD) begin
            exp[len] = 8'h06;
            slen     = len + 1;
        end else begin
            slen = 2 * nbeats;
        end
        if (slen % rate != 0) slen = slen + rate - (slen % rate);
        if (PAD) exp[slen-1] = exp[slen-1] | 8'h80;
        nblk = slen / rate;

        b = 0; bi = 0; vcnt = 0; pads = 0; snap = '0;
        for (int cyc = 0; cyc < 4000 && bi < nblk; cyc++) begin
            @(negedge ACLK);
            if (b < nbeats) begin
                S_TVALID = 1'b1;
                S_TDATA  = {(2*b+1 < len) ? msg[2*b+1] : 8'h00, (2*b < len) ? msg[2*b] : 8'h00};
                S_TKEEP  = {2*b+1 < len, 2*b < len};
                S_TLAST  = (b == nbeats - 1);
                S_TUSER  = (b == 0) ? mode : ~mode;
            end else begin
                S_TVALID = 1'b0;
                S_TDATA  = '0;
                S_TKEEP  = '0;
                S_TLAST  = 1'b0;
            end
            Block_ready = (bp == 0) ? 1'b1 : (Block_valid && vcnt >= bp);
            #1;
            if (!S_TREADY && !Block_valid) pads++;
            if (Block_valid) begin
                if (vcnt == 0) begin
                    snap = Block;
                end else begin
                    chk_blk("hold_block", Block, snap);
                    chk("hold_ready", 32'(S_TREADY), 32'd0);
                end
                if (Block_ready) begin
                    ev = '0;
                    for (int j = 0; j < rate; j++) ev[8*j +: 8] = exp[bi*rate + j];
                    chk_blk("block", Block, ev);
                    chk("first", 32'(Block_first), 32'(bi == 0));
                    chk("last", 32'(Block_last), 32'(bi == nblk - 1));
                    chk("mode", 32'(Mode), 32'(mode));
                    if (bi < 4) cap[bi] = Block;
                    bi++;
                    vcnt = 0;
                end else begin
                    vcnt++;
                end
            end
            if (S_TVALID && S_TREADY) b++;
        end
        nblk_seen = bi;
        chk("blocks_done", 32'(bi), 32'(nblk));
        chk("beats_taken", 32'(b), 32'(nbeats));
        chk("pad_cycles", 32'(pads), 32'(exp_pad));
        @(negedge ACLK);
        S_TVALID    = 1'b0;
        S_TLAST     = 1'b0;
        Block_ready = 1'b0;
        #1;
        chk("ready_after", 32'(S_TREADY), 32'd1);
    endtask

    initial begin
        ARESET      = 1'b1;
        S_TDATA     = '0;
        S_TKEEP     = '0;
        S_TVALID    = 1'b0;
        S_TLAST     = 1'b0;
        S_TUSER     = 2'd0;
        Block_ready = 1'b0;
        repeat (2) @(negedge ACLK);
        chk("rst_tready", 32'(S_TREADY), 32'd0);
        chk("rst_valid", 32'(Block_valid), 32'd0);
        chk("rst_first", 32'(Block_first), 32'd0);
        chk("rst_last", 32'(Block_last), 32'd0);
        chk("rst_mode", 32'(Mode), 32'd0);
        chk("rst_block", 32'(|Block), 32'd0);
        ARESET = 1'b0;
        #1;
        chk("rst_tready_rel", 32'(S_TREADY), 32'd1);

        // Empty message, mode 1
        run_msg(2'd1, 0, 0, 67);
        chk("empty_nblk", 32'(nblk_seen), 32'd1);
        chk("empty_b0", 32'(cap[0][7:0]), PAD ? 32'h06 : 32'h00);
        chk("empty_b135", 32'(cap[0][1087:1080]), PAD ? 32'h80 : 32'h00);

        // "abc", mode 1
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg(2'd1, 3, 0, 66);
        chk("abc_w", cap[0][31:0], PAD ? 32'h06636261 : 32'h00636261);
        chk("abc_b135", 32'(cap[0][1087:1080]), PAD ? 32'h80 : 32'h00);

        // 71 bytes, mode 3: pad and final bit share byte 71
        pattern(71, 1);
        run_msg(2'd3, 71, 0, 0);
        chk("m71_b71", 32'(cap[0][575:568]), PAD ? 32'h86 : 32'h00);
        chk("m71_above", 32'(|cap[0][1599:576]), 32'd0);

        // 72 bytes, mode 3: padding spills into a second block built by PAD
        pattern(72, 1);
        run_msg(2'd3, 72, 0, PAD ? 36 : 0);
        chk("m72_nblk", 32'(nblk_seen), PAD ? 32'd2 : 32'd1);
        chk("m72_b71", 32'(cap[0][575:568]), 32'h48);
        if (PAD) begin
            chk("m72_blk2_b0", 32'(cap[1][7:0]), 32'h06);
            chk("m72_blk2_b71", 32'(cap[1][575:568]), 32'h80);
        end

        // Backpressure, mode 2
        pattern(30, 9);
        run_msg(2'd2, 30, 5, 37);

        // Mode 0, short message
        pattern(20, 3);
        run_msg(2'd0, 20, 0, 62);

        // Multi-block, mode 3, HOLD back into FILL
        pattern(200, 5);
        run_msg(2'd3, 200, 2, 8);
        chk("multi_nblk", 32'(nblk_seen), 32'd3);

        // Reset in the middle of a fill discards everything
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            S_TVALID = 1'b1;
            S_TDATA  = 16'hA5A5 ^ 16'(i);
            S_TKEEP  = 2'b11;
            S_TLAST  = 1'b0;
            S_TUSER  = 2'd1;
            #1;
            if (i == 0 || i == 9) chk("mid_ready", 32'(S_TREADY), 32'd1);
        end
        @(negedge ACLK);
        S_TVALID = 1'b0;
        ARESET   = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(S_TREADY), 32'd0);
        @(negedge ACLK);
        chk("mid_rst_valid", 32'(Block_valid), 32'd0);
        chk("mid_rst_block", 32'(|Block), 32'd0);
        ARESET = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(S_TREADY), 32'd1);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        run_msg(2'd1, 3, 0, 66);
        chk("abc2_w", cap[0][31:0], PAD ? 32'h06636261 : 32'h00636261);
        chk("abc2_nblk", 32'(nblk_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sha_absorb.md
# sha_absorb

Input-side AXI-Stream absorber for the SHA-3 core. It accepts message bytes as DATA_WIDTH-wide stream beats and selects the rate from the per-message mode (SHA3-224/256/384/512). It applies FIPS-202 padding (0x06 … 0x80) and packs the bytes into rate-sized blocks. Each block is handed to the Keccak permutation stage, with first/last flags, over a valid/ready handshake. It is the write-side counterpart of the digest serializer that shifts the final state out.

## Interface
- DATA_WIDTH, 16: stream beat width in bits; legal values 8, 16, 32, 64.
- ACLK  in  1  clock; all logic on rising edge; one clock domain.
- ARESET  in  1  reset; synchronous, active-high.
- S_TDATA  in  DATA_WIDTH  message bytes; first stream byte in [7:0].
- S_TKEEP  in  DATA_WIDTH/8  byte enables; contiguous from bit 0; honoured only on the TLAST beat; all-ones assumed otherwise.
- S_TVALID  in  1  beat valid.
- S_TREADY  out  1  beat accepted when S_TVALID&&S_TREADY.
- S_TLAST  in  1  final beat of message.
- S_TUSER  in  2  mode: 0=224 (rate 144 B), 1=256 (136 B), 2=384 (104 B), 3=512 (72 B); sampled on a message's first beat only.
- Block  out  1600  rate bytes in low bits, byte j at [8j+7:8j]; bits above the rate are 0.
- Block_valid  out  1  Block is complete and stable.
- Block_ready  in  1  permutation stage takes the block.
- Block_first  out  1  first block of the message; the core zeroes its state before XOR.
- Block_last  out  1  final block; the core starts digest output after the permutation.
- Mode  out  2  latched S_TUSER for the current message.

## Operation
- FSM states:
  - IDLE: S_TREADY=1. First beat → latch Mode, write word 0, set first_flag; go to FILL, or to PAD/HOLD if TLAST.
  - FILL: S_TREADY=1. Each beat is written at word index cnt (cnt 0..rate/DATA_WIDTH−1). The last word of the block → HOLD. A TLAST beat → padding as below.
  - PAD: S_TREADY=0. Writes one zero word per cycle until the block is full. The pad byte and the 0x80 bit are inserted as below. → HOLD.
  - HOLD: S_TREADY=0, Block_valid=1. On handshake: clear the buffer and cnt, clear first_flag. Go to IDLE if Block_last, else FILL.
- Padding on a TLAST beat with k = popcount(S_TKEEP):
  - k < DATA_WIDTH/8: byte k of that word = 0x06.
  - k = DATA_WIDTH/8: pad_pending is set, and 0x06 goes into byte 0 of the next word. If the block is already full, that next word is word 0 of a new block, filled via PAD.
  - The final rate byte is ORed with 0x80. The pad byte and the final byte coincide → 0x86.
- Block_last=1 for the block containing the 0x06 byte.
- S_TKEEP=0 on TLAST is a legal empty final beat; 0x06 goes into byte 0 of that word.
- Non-TLAST beats with partial TKEEP are treated as full.
- S_TUSER changes mid-message are ignored.

## Timing
- Reset values: S_TREADY=0, Block_valid=0, Block_first=0, Block_last=0, Mode=0, Block=0. FSM goes to IDLE.
- S_TREADY=1 from the first cycle after ARESET deasserts.
- ARESET during any state discards the partial block and pad_pending; no block is emitted.
- Block_valid rises the cycle after the block's final word is written, either accepted or produced in PAD.
- PAD takes one cycle per remaining word.
- Block, Block_first, Block_last and Mode are held constant while Block_valid=1 and Block_ready=0.
- Minimum gap between blocks: one cycle (the HOLD handshake cycle). S_TREADY returns the cycle after the handshake.
- Block_ready while Block_valid=0 is ignored.

## Configuration
- SHA_ABSORB_PAD_EN:
  - Defined: hardware padding as above.
  - Undefined: no pad bytes are inserted and S_TKEEP is ignored. The message must be pre-padded.
  - Undefined, TLAST on a non-final word: the remainder of the block is zero-filled via PAD and the block is flagged Block_last. No extra block is ever generated.

## Test plan
- Empty message, DATA_WIDTH=16, S_TUSER=1, one beat TLAST, TKEEP=2'b00 → one block. Block[7:0]=0x06, Block[1087:1080]=0x80, all other bits 0, first=last=1, Mode=1.
- "abc", S_TUSER=1: beats 0x6261 (TKEEP 11), then 0x0063 (TKEEP 01, TLAST) → Block[31:0]=0x06636261, Block[1087:1080]=0x80, single block.
- 71-byte message, S_TUSER=3: 35 full beats, then TKEEP 01 with TLAST → single block. Block[575:568]=0x86, Block[1599:576]=0.
- 72-byte message, S_TUSER=3, TLAST on beat 36 → two blocks:
  - Block 1: data only, first=1, last=0.
  - Block 2: byte0=0x06, byte71=0x80, rest 0, first=0, last=1.
  - S_TREADY=0 for the 36 PAD cycles.
- Backpressure: Block_ready held 0 for 5 cycles after Block_valid → S_TREADY=0 and Block unchanged throughout. S_TREADY=1 the cycle after the handshake.
- Reset mid-fill: 10 beats, then ARESET for 1 cycle → Block_valid=0. A following "abc" message yields exactly the block from test 2, with no stale bytes.
